// File: rtl/pedo_pkg.sv
// Shared types, encodings and default limits for the pedometer statistics stage.
package pedo_pkg;

  localparam int unsigned STEP_MAX_DEF    = 9999;
  localparam int unsigned OVER_THRESH_DEF = 32;
  localparam int unsigned HIGH_THRESH_DEF = 64;
  localparam int unsigned HIGH_RUN_DEF    = 60;
  localparam int unsigned FIRST_WINDOW    = 9;
  localparam int unsigned DISP_HOLD       = 2;

  localparam int unsigned CNT_W = 16;
  localparam int unsigned WIN_W = 8;
  localparam int unsigned RUN_W = 6;
  localparam int unsigned SEL_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUILD = 2'd1,
    HIGH  = 2'd2
  } act_state_t;

  typedef enum logic [SEL_W-1:0] {
    DISP_STEPS = 2'd0,
    DISP_DIST  = 2'd1,
    DISP_OVER  = 2'd2,
    DISP_HIGH  = 2'd3
  } disp_sel_t;

  // Add with saturation at lim; the carry bit keeps the overflow visible.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b,
                                               input logic [CNT_W-1:0] lim);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, lim}) sat_add = lim;
    else                   sat_add = sum[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
module sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic evt
);

  logic [2:0] sh;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh  <= 3'b000;
      evt <= 1'b0;
    end else begin
      sh  <= {sh[1:0], din};
      evt <= sh[1] & ~sh[2];
    end
  end

endmodule

// File: rtl/step_tracker.sv
// Pedometer statistics: step total, distance, early over-threshold seconds,
// sustained high-activity time and a rotating display value.
module step_tracker
  import pedo_pkg::*;
#(
  parameter int unsigned STEP_MAX    = STEP_MAX_DEF,
  parameter int unsigned OVER_THRESH = OVER_THRESH_DEF,
  parameter int unsigned HIGH_THRESH = HIGH_THRESH_DEF,
  parameter int unsigned HIGH_RUN    = HIGH_RUN_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pulse_in,
  input  logic             sec_in,
  input  logic             enable,
  output logic [CNT_W-1:0] step_count,
  output logic [3:0]       dist_half,
  output logic [3:0]       over32_secs,
  output logic [CNT_W-1:0] high_secs,
  output logic             step_sat,
  output logic [SEL_W-1:0] disp_sel,
  output logic [CNT_W-1:0] disp_value
);

  localparam logic [CNT_W-1:0] STEP_LIM = CNT_W'(STEP_MAX);
  localparam logic [WIN_W-1:0] OVER_T   = WIN_W'(OVER_THRESH);
  localparam logic [WIN_W-1:0] HIGH_T   = WIN_W'(HIGH_THRESH);
  localparam logic [RUN_W-1:0] RUN_T    = RUN_W'(HIGH_RUN);
  localparam logic [WIN_W-1:0] FIRST_T  = WIN_W'(FIRST_WINDOW);
  localparam logic             HOLD_TOP = 1'(DISP_HOLD - 1);

  logic step_evt;
  logic sec_evt;

  sync_edge u_step_sync (.clk(clk), .reset(reset), .din(pulse_in), .evt(step_evt));
  sync_edge u_sec_sync  (.clk(clk), .reset(reset), .din(sec_in),   .evt(sec_evt));

  act_state_t       state, state_nxt;
  logic [RUN_W-1:0] run, run_nxt;
  logic [WIN_W-1:0] win_cnt, win_nxt;
  logic [WIN_W-1:0] elapsed, elapsed_nxt;
  logic [WIN_W-1:0] w;
  logic [CNT_W-1:0] step_nxt, high_nxt;
  logic [3:0]       over_nxt;
  logic             hold, hold_nxt;
  logic [SEL_W-1:0] sel_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      run         <= '0;
      win_cnt     <= '0;
      elapsed     <= '0;
      step_count  <= '0;
      high_secs   <= '0;
      over32_secs <= '0;
      hold        <= 1'b0;
      disp_sel    <= '0;
    end else begin
      state       <= state_nxt;
      run         <= run_nxt;
      win_cnt     <= win_nxt;
      elapsed     <= elapsed_nxt;
      step_count  <= step_nxt;
      high_secs   <= high_nxt;
      over32_secs <= over_nxt;
      hold        <= hold_nxt;
      disp_sel    <= sel_nxt;
    end
  end

  // Next-state for counters, activity FSM and display rotation.
  always_comb begin
    state_nxt   = state;
    run_nxt     = run;
    win_nxt     = win_cnt;
    elapsed_nxt = elapsed;
    step_nxt    = step_count;
    high_nxt    = high_secs;
    over_nxt    = over32_secs;
    hold_nxt    = hold;
    sel_nxt     = disp_sel;

    // A step landing on the closing edge belongs to the closing window.
    w = (win_cnt == '1) ? win_cnt : win_cnt + WIN_W'(step_evt);

    if (enable && step_evt) begin
      step_nxt = (step_count >= STEP_LIM) ? step_count : step_count + CNT_W'(1);
      win_nxt  = (win_cnt == '1) ? win_cnt : win_cnt + WIN_W'(1);
    end

    if (enable && sec_evt) begin
      elapsed_nxt = (elapsed == '1) ? elapsed : elapsed + WIN_W'(1);
      if (elapsed_nxt <= FIRST_T && w > OVER_T) over_nxt = over32_secs + 4'd1;
      win_nxt = '0;

      if (hold == HOLD_TOP) begin
        hold_nxt = 1'b0;
        sel_nxt  = disp_sel + SEL_W'(1);
      end else begin
        hold_nxt = hold + 1'b1;
      end

      case (state)
        IDLE: begin
          if (w >= HIGH_T) begin
            state_nxt = BUILD;
            run_nxt   = RUN_W'(1);
          end
        end
        BUILD: begin
          if (w < HIGH_T) begin
            state_nxt = IDLE;
            run_nxt   = '0;
          end else begin
            run_nxt = run + RUN_W'(1);
            if (run_nxt == RUN_T) begin
              state_nxt = HIGH;
              high_nxt  = sat_add(high_secs, CNT_W'(HIGH_RUN), STEP_LIM);
            end
          end
        end
        HIGH: begin
          if (w >= HIGH_T) begin
            high_nxt = sat_add(high_secs, CNT_W'(1), STEP_LIM);
          end else begin
            state_nxt = IDLE;
            run_nxt   = '0;
          end
        end
        default: begin
          state_nxt = IDLE;
          run_nxt   = '0;
        end
      endcase
    end
  end

  assign dist_half = step_count[13:10];
  assign step_sat  = (step_count == STEP_LIM);

  always_comb begin
    disp_value = step_count;
    case (disp_sel)
      DISP_STEPS: disp_value = step_count;
      DISP_DIST:  disp_value = {12'd0, dist_half};
      DISP_OVER:  disp_value = {12'd0, over32_secs};
      DISP_HIGH:  disp_value = high_secs;
      default:    disp_value = step_count;
    endcase
  end

endmodule
